// File: rtl/mcpu_core_pkg.sv
// Shared core definitions: lane geometry, register file sizes and the load-return entry.
// Lane i of a packed vector occupies [i*REG_W +: REG_W] for numbers and [i*DATA_W +: DATA_W] for data.
package mcpu_core_pkg;

  localparam int NUM_LANES = 4;
  localparam int REG_W     = 5;
  localparam int DATA_W    = 32;
  localparam int NUM_REGS  = 32;

  typedef logic [REG_W-1:0]  reg_num_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  typedef struct packed {
    reg_num_t  num;
    reg_data_t data;
  } ldq_entry_t;

endpackage

// File: rtl/mcpu_core_wb_ldq.sv
// Load-return queue: circular buffer with occupancy counter, exposing the oldest
// DRAIN_MAX entries and popping a variable number of them per cycle.
module mcpu_core_wb_ldq
  import mcpu_core_pkg::*;
#(
  parameter int LDQ_DEPTH = 4,
  parameter int DRAIN_MAX = 2,
  localparam int PTR_W    = $clog2(LDQ_DEPTH),
  localparam int CNT_W    = PTR_W + 1
) (
  input  logic                       clkrst_core_clk,
  input  logic                       clkrst_core_rst,
  input  logic                       push_valid_i,
  input  ldq_entry_t                 push_entry_i,
  output logic                       ready_o,
  output ldq_entry_t [DRAIN_MAX-1:0] peek_o,
  input  logic [CNT_W-1:0]           pop_cnt_i,
  output logic [CNT_W-1:0]           count_o
);

  ldq_entry_t       mem_q [LDQ_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;

  // Ready depends only on occupancy, so a same-cycle pop never frees a slot for a push.
  assign ready_o = (count_q != CNT_W'(LDQ_DEPTH));
  assign push    = push_valid_i & ready_o;
  assign count_o = count_q;

  for (genvar gi = 0; gi < DRAIN_MAX; gi++) begin : g_peek
    assign peek_o[gi] = mem_q[rd_ptr_q + PTR_W'(gi)];
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q + pop_cnt_i[PTR_W-1:0];
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    count_d  = count_q + CNT_W'(push) - pop_cnt_i;
  end

  always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
    if (clkrst_core_rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clkrst_core_clk) begin
    if (push && !clkrst_core_rst) begin
      mem_q[wr_ptr_q] <= push_entry_i;
    end
  end

endmodule

// File: rtl/mcpu_core_writeback.sv
// Writeback stage: registers per-lane results, drains late load returns into idle
// lanes and tracks registers with outstanding loads for decode interlocking.
module mcpu_core_writeback
  import mcpu_core_pkg::*;
#(
  parameter int LDQ_DEPTH = 4,
  parameter int DRAIN_MAX = 2
) (
  input  logic                        clkrst_core_clk,
  input  logic                        clkrst_core_rst,
  input  logic [NUM_LANES-1:0]        m2wb_valid,
  input  logic [NUM_LANES*REG_W-1:0]  m2wb_rd_num,
  input  logic [NUM_LANES*DATA_W-1:0] m2wb_rd_data,
  input  logic [NUM_LANES-1:0]        m2wb_rd_we,
  input  logic [NUM_LANES-1:0]        m2wb_pred_we,
  input  logic [NUM_LANES-1:0]        m2wb_is_load,
  input  logic                        mem2wb_ld_valid,
  input  logic [REG_W-1:0]            mem2wb_ld_rd_num,
  input  logic [DATA_W-1:0]           mem2wb_ld_data,
  output logic                        mem2wb_ld_ready,
  output logic [NUM_LANES*REG_W-1:0]  wb2rf_rd_num,
  output logic [NUM_LANES*DATA_W-1:0] wb2rf_rd_data,
  output logic [NUM_LANES-1:0]        wb2rf_rd_we,
  output logic [NUM_LANES-1:0]        wb2rf_pred_we,
  output logic [NUM_REGS-1:0]         wb2d_pending,
  output logic [$clog2(LDQ_DEPTH):0]  wb2d_ldq_count
);

  localparam int CNT_W = $clog2(LDQ_DEPTH) + 1;

  ldq_entry_t [DRAIN_MAX-1:0] ldq_peek;
  ldq_entry_t                 ldq_push_entry;
  logic [CNT_W-1:0]           ldq_count;
  logic [CNT_W-1:0]           ldq_pop_cnt;
  logic [NUM_LANES-1:0]       lane_free;
  int                         free_cnt;
  int                         drain_k;
  int                         drain_slot;

  logic [NUM_LANES-1:0]        rd_we_q, rd_we_d;
  logic [NUM_LANES-1:0]        pred_we_q, pred_we_d;
  logic [NUM_LANES*REG_W-1:0]  rd_num_q, rd_num_d;
  logic [NUM_LANES*DATA_W-1:0] rd_data_q, rd_data_d;
  logic [NUM_REGS-1:0]         pending_q, pending_d;
  logic [NUM_REGS-1:0]         pending_set, pending_clr;
  logic                        rf_collide;

  assign ldq_push_entry = '{num: mem2wb_ld_rd_num, data: mem2wb_ld_data};

  mcpu_core_wb_ldq #(
    .LDQ_DEPTH (LDQ_DEPTH),
    .DRAIN_MAX (DRAIN_MAX)
  ) u_ldq (
    .clkrst_core_clk (clkrst_core_clk),
    .clkrst_core_rst (clkrst_core_rst),
    .push_valid_i    (mem2wb_ld_valid),
    .push_entry_i    (ldq_push_entry),
    .ready_o         (mem2wb_ld_ready),
    .peek_o          (ldq_peek),
    .pop_cnt_i       (ldq_pop_cnt),
    .count_o         (ldq_count)
  );

  // A lane is free when it produces no register file write this cycle.
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_free
    assign lane_free[gi] = ~m2wb_valid[gi] | m2wb_is_load[gi] |
                           ~(m2wb_rd_we[gi] | m2wb_pred_we[gi]);
  end

  always_comb begin
    free_cnt = 0;
    for (int i = 0; i < NUM_LANES; i++) begin
      free_cnt = free_cnt + (lane_free[i] ? 1 : 0);
    end
    drain_k = int'(ldq_count);
    if (free_cnt < drain_k) drain_k = free_cnt;
    if (DRAIN_MAX < drain_k) drain_k = DRAIN_MAX;
  end

  assign ldq_pop_cnt = CNT_W'(drain_k);

  // Oldest entry goes to the lowest free lane; drain_slot counts free lanes seen so far.
  always_comb begin
    rd_we_d     = '0;
    pred_we_d   = '0;
    rd_num_d    = '0;
    rd_data_d   = '0;
    pending_clr = '0;
    drain_slot  = 0;
    for (int i = 0; i < NUM_LANES; i++) begin
      rd_we_d[i]                   = m2wb_valid[i] & m2wb_rd_we[i] & ~m2wb_is_load[i];
      pred_we_d[i]                 = m2wb_valid[i] & m2wb_pred_we[i] & ~m2wb_is_load[i];
      rd_num_d[i*REG_W +: REG_W]   = m2wb_rd_num[i*REG_W +: REG_W];
      rd_data_d[i*DATA_W +: DATA_W] = m2wb_rd_data[i*DATA_W +: DATA_W];
      if (lane_free[i]) begin
        for (int j = 0; j < DRAIN_MAX; j++) begin
          if (drain_slot == j && j < drain_k) begin
            rd_we_d[i]                    = 1'b1;
            pred_we_d[i]                  = 1'b0;
            rd_num_d[i*REG_W +: REG_W]    = ldq_peek[j].num;
            rd_data_d[i*DATA_W +: DATA_W] = ldq_peek[j].data;
            pending_clr[ldq_peek[j].num]  = 1'b1;
          end
        end
        drain_slot = drain_slot + 1;
      end
    end
  end

  // Clear first, then set, so a new load to a register wins over its old return draining.
  always_comb begin
    pending_set = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (m2wb_valid[i] && m2wb_is_load[i] && m2wb_rd_we[i]) begin
        pending_set[m2wb_rd_num[i*REG_W +: REG_W]] = 1'b1;
      end
    end
    pending_d = (pending_q & ~pending_clr) | pending_set;
  end

  always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
    if (clkrst_core_rst) begin
      rd_we_q   <= '0;
      pred_we_q <= '0;
      rd_num_q  <= '0;
      rd_data_q <= '0;
      pending_q <= '0;
    end else begin
      rd_we_q   <= rd_we_d;
      pred_we_q <= pred_we_d;
      rd_num_q  <= rd_num_d;
      rd_data_q <= rd_data_d;
      pending_q <= pending_d;
    end
  end

  assign wb2rf_rd_we    = rd_we_q;
  assign wb2rf_pred_we  = pred_we_q;
  assign wb2rf_rd_num   = rd_num_q;
  assign wb2rf_rd_data  = rd_data_q;
  assign wb2d_pending   = pending_q;
  assign wb2d_ldq_count = ldq_count;

  always_comb begin
    rf_collide = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      for (int j = i + 1; j < NUM_LANES; j++) begin
        if (rd_we_q[i] && rd_we_q[j] &&
            rd_num_q[i*REG_W +: REG_W] == rd_num_q[j*REG_W +: REG_W]) begin
          rf_collide = 1'b1;
        end
      end
    end
  end

  a_no_lane_collision: assert property (@(posedge clkrst_core_clk)
    disable iff (clkrst_core_rst) !rf_collide);

  a_drain_was_pending: assert property (@(posedge clkrst_core_clk)
    disable iff (clkrst_core_rst) (pending_clr & ~pending_q) == '0);

endmodule
